// File: rtl/pbkdf2_pkg.sv
// pbkdf2_pkg: shared states, frame geometry and error-bit positions for the pbkdf2 host.
package pbkdf2_pkg;
    typedef enum logic [1:0] {ST_LOAD, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;
    localparam int WORD_W    = 32;
    localparam int JOB_WORDS = 34;
    localparam int OUT_WORDS = 8;
    localparam logic [5:0] IDX_ITERS = 6'd0;
    localparam logic [5:0] IDX_SLEN  = 6'd1;
    localparam logic [5:0] IDX_PASS0 = 6'd2;
    localparam logic [5:0] IDX_SALT0 = 6'd18;
    localparam logic [5:0] IDX_LAST  = 6'(JOB_WORDS - 1);
    localparam int ERR_FRAME = 0;
    localparam int ERR_ITERS = 1;
endpackage

// File: rtl/pbkdf2_word_ser.sv
// pbkdf2_word_ser: loads a 256-bit hash and streams it MSW first as 32-bit valid/ready/last words.
module pbkdf2_word_ser
    import pbkdf2_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [255:0] hash_i,
    input  logic         m_ready_i,
    output logic [31:0]  m_data_o,
    output logic         m_valid_o,
    output logic         m_last_o,
    output logic         done_o
);
    logic [255:0] sh;
    logic [2:0]   k;
    logic         valid;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sh    <= '0;
            k     <= '0;
            valid <= 1'b0;
        end else if (load_i) begin
            sh    <= hash_i;
            k     <= '0;
            valid <= 1'b1;
        end else if (valid && m_ready_i) begin
            sh    <= {sh[223:0], 32'h0};
            k     <= k + 3'd1;
            valid <= k != 3'(OUT_WORDS - 1);
        end
    end

    always_comb begin
        m_data_o  = sh[255 -: 32];
        m_valid_o = valid;
        m_last_o  = valid && (k == 3'(OUT_WORDS - 1));
        done_o    = m_last_o && m_ready_i;
    end
endmodule

// File: rtl/pbkdf2_host.sv
// pbkdf2_host: collects a 34-word job frame, issues it to the pbkdf2 core and streams back the 256-bit hash.
module pbkdf2_host
    import pbkdf2_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  s_data_i,
    input  logic         s_valid_i,
    input  logic         s_last_i,
    output logic         s_ready_o,
    output logic         core_in_valid_o,
    input  logic         core_in_ready_i,
    output logic [31:0]  core_iters_o,
    output logic [511:0] core_pass_o,
    output logic [511:0] core_salt_o,
    output logic [5:0]   core_salt_len_o,
    input  logic         core_out_valid_i,
    output logic         core_out_ready_o,
    input  logic [255:0] core_hash_i,
    output logic [31:0]  m_data_o,
    output logic         m_valid_o,
    output logic         m_last_o,
    input  logic         m_ready_i,
    output logic [1:0]   err_o,
    input  logic         err_clr_i,
    output logic [15:0]  jobs_done_o
);
    state_t       state, nxt;
    logic [5:0]   idx;
    logic [31:0]  iters;
    logic [5:0]   slen;
    logic [511:0] pass, salt;
    logic [1:0]   err;
    logic [15:0]  jobs_done;
    logic         acc, at_last, frame_err, iters_err, job_ok, capture, ser_done;

    always_comb begin
        acc       = (state == ST_LOAD) && s_valid_i;
        at_last   = idx == IDX_LAST;
        frame_err = acc && (s_last_i != at_last);
        iters_err = acc && at_last && s_last_i && (iters == '0);
        job_ok    = acc && at_last && s_last_i && (iters != '0);
        capture   = (state == ST_WAIT) && core_out_valid_i;
        nxt       = state;
        unique case (state)
            ST_LOAD:  nxt = job_ok ? ST_ISSUE : ST_LOAD;
            ST_ISSUE: nxt = core_in_ready_i ? ST_WAIT : ST_ISSUE;
            ST_WAIT:  nxt = core_out_valid_i ? ST_DRAIN : ST_WAIT;
            ST_DRAIN: nxt = ser_done ? ST_LOAD : ST_DRAIN;
            default:  nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= ST_LOAD;
        else        state <= nxt;
    end

    // Pass and salt shift in MSW first, so after 16 words the first one sits at [511:480].
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idx       <= '0;
            iters     <= '0;
            slen      <= '0;
            pass      <= '0;
            salt      <= '0;
            err       <= '0;
            jobs_done <= '0;
        end else begin
            if (acc) begin
                idx <= (frame_err || at_last) ? 6'd0 : idx + 6'd1;
                if (idx == IDX_ITERS) iters <= s_data_i;
                if (idx == IDX_SLEN)  slen  <= s_data_i[5:0];
                if (idx >= IDX_PASS0 && idx < IDX_SALT0) pass <= {pass[479:0], s_data_i};
                if (idx >= IDX_SALT0) salt <= {salt[479:0], s_data_i};
            end
            err[ERR_FRAME] <= (err[ERR_FRAME] && !err_clr_i) || frame_err;
            err[ERR_ITERS] <= (err[ERR_ITERS] && !err_clr_i) || iters_err;
            if (capture) jobs_done <= jobs_done + 16'd1;
        end
    end

    pbkdf2_word_ser u_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (capture),
        .hash_i    (core_hash_i),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .done_o    (ser_done)
    );

    // Ready is masked while reset is held so nothing reports acceptance during reset.
    always_comb begin
        s_ready_o        = rst_i && (state == ST_LOAD);
        core_in_valid_o  = state == ST_ISSUE;
        core_out_ready_o = state == ST_WAIT;
        core_iters_o     = iters;
        core_pass_o      = pass;
        core_salt_o      = salt;
        core_salt_len_o  = slen;
        err_o            = err;
        jobs_done_o      = jobs_done;
    end
endmodule
